// File: rtl/peripheral_msi_ahb4_pkg.sv
// Shared AHB4-Lite encodings and master FSM state for the MSI AHB4 master engine.
package peripheral_msi_ahb4_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HBURST encodings used by this master
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    // HSIZE encodings
    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    // Master FSM: normal issue, error recovery, replay of the cancelled command
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_ERR    = 2'b01,
        ST_REPLAY = 2'b10
    } mst_state_e;

    // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not
    function automatic logic trans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/peripheral_msi_ahb4_seq_detect.sv
// Burst-continuation check: decides whether a new command can follow the
// transfer currently in the address phase as an INCR SEQ beat.
// Only compiled when PERIPHERAL_MSI_AHB4_INCR_BURST_EN is defined.
`ifdef PERIPHERAL_MSI_AHB4_INCR_BURST_EN
module peripheral_msi_ahb4_seq_detect
    import peripheral_msi_ahb4_pkg::*;
#(
    parameter int PLEN = 64
) (
    input  logic            prev_valid_i,
    input  logic            prev_write_i,
    input  logic [2:0]      prev_size_i,
    input  logic [PLEN-1:0] prev_addr_i,
    input  logic            cmd_write_i,
    input  logic [2:0]      cmd_size_i,
    input  logic [PLEN-1:0] cmd_addr_i,
    output logic            seq_o
);

    logic [PLEN-1:0] next_addr;

    // Contiguous, same direction and size, and inside the same 1 KB page
    always_comb begin
        next_addr = prev_addr_i + (PLEN'(1) << prev_size_i);
        seq_o     = prev_valid_i
                 && (cmd_write_i == prev_write_i)
                 && (cmd_size_i == prev_size_i)
                 && (cmd_addr_i == next_addr)
                 && (cmd_addr_i[PLEN-1:10] == prev_addr_i[PLEN-1:10]);
    end

endmodule
`endif

// File: rtl/peripheral_msi_master_ahb4.sv
// AHB4-Lite master engine: turns a valid/ready command stream into pipelined
// AHB-Lite transfers (address phase AP, data phase DP) and returns one
// in-order response per command. An ERROR response cancels the command in AP,
// which is replayed after the error completes.
// Optional: PERIPHERAL_MSI_AHB4_INCR_BURST_EN issues contiguous runs as INCR bursts.
module peripheral_msi_master_ahb4
    import peripheral_msi_ahb4_pkg::*;
#(
    parameter int         XLEN          = 64,
    parameter int         PLEN          = 64,
    parameter logic [3:0] HPROT_DEFAULT = 4'b0011
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [PLEN-1:0] cmd_addr,
    input  logic [2:0]      cmd_size,
    input  logic [XLEN-1:0] cmd_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_error,
    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADY,
    input  logic            HRESP
);

    mst_state_e state_q, state_d;

    // Address phase: the AHB control outputs plus the command's write data
    logic            hsel_q;
    logic [PLEN-1:0] haddr_q;
    logic            hwrite_q;
    logic [2:0]      hsize_q;
    logic [2:0]      hburst_q;
    logic [1:0]      htrans_q;
    logic [XLEN-1:0] ap_wdata_q;

    // Data phase
    logic            dp_valid_q;
    logic            dp_write_q;
    logic [XLEN-1:0] hwdata_q;

    // Command cancelled by an ERROR response, waiting to be re-issued
    logic            rp_valid_q;
    logic            rp_write_q;
    logic [PLEN-1:0] rp_addr_q;
    logic [2:0]      rp_size_q;
    logic [XLEN-1:0] rp_wdata_q;

    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            rsp_error_q;

    logic            ap_valid;
    logic            cmd_accept;
    logic            err_enter;
    logic [1:0]      cmd_trans;
    logic [2:0]      cmd_burst;

    assign ap_valid   = trans_active(htrans_q);
    assign cmd_ready  = !HRESET && HREADY && (state_q == ST_RUN);
    assign cmd_accept = cmd_valid && cmd_ready;
    // First cycle of a two-cycle ERROR response on the transfer in DP
    assign err_enter  = (state_q == ST_RUN) && HRESP && !HREADY && dp_valid_q;

`ifdef PERIPHERAL_MSI_AHB4_INCR_BURST_EN
    logic cmd_seq;

    peripheral_msi_ahb4_seq_detect #(
        .PLEN (PLEN)
    ) u_seq_detect (
        .prev_valid_i (ap_valid && (hburst_q == HBURST_INCR)),
        .prev_write_i (hwrite_q),
        .prev_size_i  (hsize_q),
        .prev_addr_i  (haddr_q),
        .cmd_write_i  (cmd_write),
        .cmd_size_i   (cmd_size),
        .cmd_addr_i   (cmd_addr),
        .seq_o        (cmd_seq)
    );

    assign cmd_trans = cmd_seq ? HTRANS_SEQ : HTRANS_NONSEQ;
    assign cmd_burst = HBURST_INCR;
`else
    assign cmd_trans = HTRANS_NONSEQ;
    assign cmd_burst = HBURST_SINGLE;
`endif

    // State register
    always_ff @(posedge HCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (HRESET) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // Next-state logic for error recovery and replay
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_RUN:    if (err_enter) state_d = ST_ERR;
            ST_ERR:    if (HREADY)    state_d = rp_valid_q ? ST_REPLAY : ST_RUN;
            ST_REPLAY: if (HREADY)    state_d = ST_RUN;
            default:                  state_d = ST_RUN;
        endcase
    end

    // AP/DP pipeline, replay capture and response generation
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hsel_q      <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= HSIZE_BYTE;
            hburst_q    <= HBURST_SINGLE;
            htrans_q    <= HTRANS_IDLE;
            ap_wdata_q  <= '0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            hwdata_q    <= '0;
            rp_valid_q  <= 1'b0;
            rp_write_q  <= 1'b0;
            rp_addr_q   <= '0;
            rp_size_q   <= HSIZE_BYTE;
            rp_wdata_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (err_enter) begin
                // Cancel the AP transfer and keep it for replay
                htrans_q <= HTRANS_IDLE;
                hsel_q   <= 1'b0;
                if (ap_valid) begin
                    rp_valid_q <= 1'b1;
                    rp_write_q <= hwrite_q;
                    rp_addr_q  <= haddr_q;
                    rp_size_q  <= hsize_q;
                    rp_wdata_q <= ap_wdata_q;
                end
            end else if (HREADY) begin
                if (dp_valid_q) begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= dp_write_q ? '0 : HRDATA;
                    rsp_error_q <= HRESP;
                end
                dp_valid_q <= ap_valid;
                dp_write_q <= hwrite_q;
                hwdata_q   <= ap_wdata_q;
                if (cmd_accept) begin
                    hsel_q     <= 1'b1;
                    haddr_q    <= cmd_addr;
                    hwrite_q   <= cmd_write;
                    hsize_q    <= cmd_size;
                    hburst_q   <= cmd_burst;
                    htrans_q   <= cmd_trans;
                    ap_wdata_q <= cmd_wdata;
                end else if (state_q == ST_REPLAY) begin
                    hsel_q     <= 1'b1;
                    haddr_q    <= rp_addr_q;
                    hwrite_q   <= rp_write_q;
                    hsize_q    <= rp_size_q;
                    hburst_q   <= HBURST_SINGLE;
                    htrans_q   <= HTRANS_NONSEQ;
                    ap_wdata_q <= rp_wdata_q;
                    rp_valid_q <= 1'b0;
                end else begin
                    hsel_q   <= 1'b0;
                    htrans_q <= HTRANS_IDLE;
                end
            end
        end
    end

    assign HSEL      = hsel_q;
    assign HADDR     = haddr_q;
    assign HWDATA    = hwdata_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = hburst_q;
    assign HTRANS    = htrans_q;
    assign HPROT     = HPROT_DEFAULT;
    assign HMASTLOCK = 1'b0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_peripheral_msi_master_ahb4.sv
// Directed bench for peripheral_msi_master_ahb4: reset, zero-wait write/read,
// wait states, ERROR with replay, burst detection (PERIPHERAL_MSI_AHB4_INCR_BURST_EN)
// and reset during a waited data phase.
module tb_peripheral_msi_master_ahb4;

`ifdef PERIPHERAL_MSI_AHB4_INCR_BURST_EN
    localparam logic [2:0] CMD_BURST = 3'b001;
    localparam bit         SEQ_EN    = 1'b1;
`else
    localparam logic [2:0] CMD_BURST = 3'b000;
    localparam bit         SEQ_EN    = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [63:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [63:0] cmd_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic        HSEL;
    logic [63:0] HADDR;
    logic [63:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [63:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int total = 0;
    int bad   = 0;

    always #5 HCLK = ~HCLK;

    peripheral_msi_master_ahb4 dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_cmd(input logic w, input logic [63:0] a, input logic [63:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = 3'd3;
        cmd_wdata = d;
    endtask

    task automatic test_reset();
        HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
        tick(); tick();
        total++; if ({HTRANS, HSEL, HWRITE, HSIZE, HBURST} !== 10'b0) begin bad++; $display("FAIL reset_ctrl got=%0h exp=0", {HTRANS, HSEL, HWRITE, HSIZE, HBURST}); end
        total++; if (HADDR !== 64'h0) begin bad++; $display("FAIL reset_haddr got=%0h exp=0", HADDR); end
        total++; if (HWDATA !== 64'h0) begin bad++; $display("FAIL reset_hwdata got=%0h exp=0", HWDATA); end
        total++; if ({HPROT, HMASTLOCK} !== {4'b0011, 1'b0}) begin bad++; $display("FAIL reset_hprot_lock got=%0h exp=6", {HPROT, HMASTLOCK}); end
        total++; if ({rsp_valid, rsp_error} !== 2'b00) begin bad++; $display("FAIL reset_rsp got=%0h exp=0", {rsp_valid, rsp_error}); end
        total++; if (rsp_rdata !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", rsp_rdata); end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_reset got=%0b exp=0", cmd_ready); end
        HRESET = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%0b exp=1", cmd_ready); end
        tick();
    endtask

    task automatic test_write_read();
        drive_cmd(1'b1, 64'h1000, 64'h1122334455667788);
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%0b exp=1", cmd_ready); end
        tick();
        total++; if ({HTRANS, HSEL, HWRITE} !== {2'b10, 1'b1, 1'b1}) begin bad++; $display("FAIL wr_ap_ctrl got=%0h exp=%0h", {HTRANS, HSEL, HWRITE}, {2'b10, 1'b1, 1'b1}); end
        total++; if (HADDR !== 64'h1000) begin bad++; $display("FAIL wr_ap_addr got=%0h exp=1000", HADDR); end
        total++; if (HBURST !== CMD_BURST) begin bad++; $display("FAIL wr_ap_burst got=%0h exp=%0h", HBURST, CMD_BURST); end
        drive_cmd(1'b0, 64'h1000, 64'h0);
        HRDATA = 64'hDEADBEEF00000001;
        tick();
        total++; if ({HTRANS, HSEL, HWRITE} !== {2'b10, 1'b1, 1'b0}) begin bad++; $display("FAIL rd_ap_ctrl got=%0h exp=%0h", {HTRANS, HSEL, HWRITE}, {2'b10, 1'b1, 1'b0}); end
        total++; if (HADDR !== 64'h1000) begin bad++; $display("FAIL rd_ap_addr got=%0h exp=1000", HADDR); end
        total++; if (HWDATA !== 64'h1122334455667788) begin bad++; $display("FAIL wr_hwdata got=%0h exp=1122334455667788", HWDATA); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_early_rsp got=%0b exp=0", rsp_valid); end
        cmd_valid = 1'b0;
        tick();
        total++; if ({rsp_valid, rsp_error} !== 2'b10) begin bad++; $display("FAIL wr_rsp got=%0h exp=2", {rsp_valid, rsp_error}); end
        total++; if (rsp_rdata !== 64'h0) begin bad++; $display("FAIL wr_rsp_rdata got=%0h exp=0", rsp_rdata); end
        total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL wr_idle_after got=%0h exp=0", HTRANS); end
        HRDATA = 64'h1122334455667788;
        tick();
        total++; if ({rsp_valid, rsp_error} !== 2'b10) begin bad++; $display("FAIL rd_rsp got=%0h exp=2", {rsp_valid, rsp_error}); end
        total++; if (rsp_rdata !== 64'h1122334455667788) begin bad++; $display("FAIL rd_rsp_rdata got=%0h exp=1122334455667788", rsp_rdata); end
        HRDATA = '0;
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_rsp_pulse got=%0b exp=0", rsp_valid); end
    endtask

    task automatic test_wait_states();
        drive_cmd(1'b0, 64'h100, 64'h0);
        tick();
        total++; if ({HTRANS, HADDR} !== {2'b10, 64'h100}) begin bad++; $display("FAIL wait_ap1 got=%0h exp=%0h", {HTRANS, HADDR}, {2'b10, 64'h100}); end
        drive_cmd(1'b0, 64'h200, 64'h0);
        tick();
        total++; if ({HTRANS, HADDR} !== {2'b10, 64'h200}) begin bad++; $display("FAIL wait_ap2 got=%0h exp=%0h", {HTRANS, HADDR}, {2'b10, 64'h200}); end
        cmd_valid = 1'b0;
        HREADY    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL wait_ready_%0d got=%0b exp=0", i, cmd_ready); end
            tick();
            total++; if ({HTRANS, HSEL, HWRITE, HADDR} !== {2'b10, 1'b1, 1'b0, 64'h200}) begin bad++; $display("FAIL wait_hold_%0d got=%0h exp=%0h", i, {HTRANS, HSEL, HWRITE, HADDR}, {2'b10, 1'b1, 1'b0, 64'h200}); end
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wait_rsp_%0d got=%0b exp=0", i, rsp_valid); end
        end
        HREADY = 1'b1;
        HRDATA = 64'hAAAA000000000100;
        tick();
        total++; if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b10, 64'hAAAA000000000100}) begin bad++; $display("FAIL wait_rsp1 got=%0h exp=%0h", {rsp_valid, rsp_error, rsp_rdata}, {2'b10, 64'hAAAA000000000100}); end
        total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL wait_idle got=%0h exp=0", HTRANS); end
        HRDATA = 64'hBBBB000000000200;
        tick();
        total++; if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b10, 64'hBBBB000000000200}) begin bad++; $display("FAIL wait_rsp2 got=%0h exp=%0h", {rsp_valid, rsp_error, rsp_rdata}, {2'b10, 64'hBBBB000000000200}); end
        HRDATA = '0;
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wait_rsp_end got=%0b exp=0", rsp_valid); end
    endtask

    task automatic test_error_replay();
        drive_cmd(1'b1, 64'h2000, 64'h55);
        tick();
        total++; if ({HTRANS, HWRITE, HADDR} !== {2'b10, 1'b1, 64'h2000}) begin bad++; $display("FAIL err_ap_wr got=%0h exp=%0h", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b1, 64'h2000}); end
        drive_cmd(1'b0, 64'h3000, 64'h0);
        tick();
        total++; if ({HTRANS, HWRITE, HADDR} !== {2'b10, 1'b0, 64'h3000}) begin bad++; $display("FAIL err_ap_rd got=%0h exp=%0h", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b0, 64'h3000}); end
        cmd_valid = 1'b0;
        HREADY    = 1'b0;
        HRESP     = 1'b1;
        tick();
        total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL err_cycle2_idle got=%0h exp=0", HTRANS); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL err_cycle2_rsp got=%0b exp=0", rsp_valid); end
        HREADY = 1'b1;
        #1;
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL err_ready got=%0b exp=0", cmd_ready); end
        tick();
        total++; if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b11, 64'h0}) begin bad++; $display("FAIL err_wr_rsp got=%0h exp=%0h", {rsp_valid, rsp_error, rsp_rdata}, {2'b11, 64'h0}); end
        total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL err_exit_idle got=%0h exp=0", HTRANS); end
        HRESP = 1'b0;
        tick();
        total++; if ({HTRANS, HSEL, HWRITE, HBURST, HADDR} !== {2'b10, 1'b1, 1'b0, 3'b000, 64'h3000}) begin bad++; $display("FAIL err_replay_ap got=%0h exp=%0h", {HTRANS, HSEL, HWRITE, HBURST, HADDR}, {2'b10, 1'b1, 1'b0, 3'b000, 64'h3000}); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL err_replay_norsp got=%0b exp=0", rsp_valid); end
        tick();
        total++; if ({HTRANS, rsp_valid} !== 3'b000) begin bad++; $display("FAIL err_replay_dp got=%0h exp=0", {HTRANS, rsp_valid}); end
        HRDATA = 64'hC0FFEE;
        tick();
        total++; if ({rsp_valid, rsp_error, rsp_rdata} !== {2'b10, 64'hC0FFEE}) begin bad++; $display("FAIL err_replay_rsp got=%0h exp=%0h", {rsp_valid, rsp_error, rsp_rdata}, {2'b10, 64'hC0FFEE}); end
        HRDATA = '0;
        tick();
        total++; if ({rsp_valid, HTRANS, cmd_ready} !== 4'b0001) begin bad++; $display("FAIL err_no_dup got=%0h exp=1", {rsp_valid, HTRANS, cmd_ready}); end
    endtask

    task automatic test_burst();
        logic [63:0] addrs [4];
        logic [63:0] datas [4];
        logic [1:0]  exp_tr [4];
        addrs = '{64'h3E8, 64'h3F0, 64'h3F8, 64'h400};
        datas = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
        if (SEQ_EN) exp_tr = '{2'b10, 2'b11, 2'b11, 2'b10};
        else        exp_tr = '{2'b10, 2'b10, 2'b10, 2'b10};
        for (int i = 0; i < 4; i++) begin
            drive_cmd(1'b1, addrs[i], datas[i]);
            tick();
            total++; if ({HTRANS, HBURST, HADDR} !== {exp_tr[i], CMD_BURST, addrs[i]}) begin bad++; $display("FAIL burst_beat_%0d got=%0h exp=%0h", i, {HTRANS, HBURST, HADDR}, {exp_tr[i], CMD_BURST, addrs[i]}); end
            total++; if (rsp_valid !== (i >= 2)) begin bad++; $display("FAIL burst_rsp_%0d got=%0b exp=%0b", i, rsp_valid, (i >= 2)); end
            if (i >= 1) begin
                total++; if (HWDATA !== datas[i-1]) begin bad++; $display("FAIL burst_wdata_%0d got=%0h exp=%0h", i, HWDATA, datas[i-1]); end
            end
        end
        cmd_valid = 1'b0;
        tick();
        total++; if ({rsp_valid, HTRANS, HWDATA} !== {3'b100, datas[3]}) begin bad++; $display("FAIL burst_tail got=%0h exp=%0h", {rsp_valid, HTRANS, HWDATA}, {3'b100, datas[3]}); end
        tick();
        total++; if ({rsp_valid, rsp_error} !== 2'b10) begin bad++; $display("FAIL burst_last_rsp got=%0h exp=2", {rsp_valid, rsp_error}); end
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL burst_end got=%0b exp=0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        drive_cmd(1'b0, 64'h500, 64'hFACE);
        tick();
        cmd_valid = 1'b0;
        tick();
        total++; if (HWDATA !== 64'hFACE) begin bad++; $display("FAIL rmid_pre_hwdata got=%0h exp=face", HWDATA); end
        HREADY = 1'b0;
        HRDATA = 64'h1234;
        tick();
        HRESET = 1'b1;
        tick();
        total++; if ({HTRANS, HSEL, HWRITE, HSIZE, HBURST} !== 10'b0) begin bad++; $display("FAIL rmid_ctrl got=%0h exp=0", {HTRANS, HSEL, HWRITE, HSIZE, HBURST}); end
        total++; if ({HADDR, HWDATA} !== 128'h0) begin bad++; $display("FAIL rmid_addr_data got=%0h exp=0", {HADDR, HWDATA}); end
        total++; if ({rsp_valid, rsp_error, rsp_rdata} !== 66'h0) begin bad++; $display("FAIL rmid_rsp got=%0h exp=0", {rsp_valid, rsp_error, rsp_rdata}); end
        HRESET = 1'b0;
        HREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if ({rsp_valid, HTRANS} !== 3'b000) begin bad++; $display("FAIL rmid_quiet_%0d got=%0h exp=0", i, {rsp_valid, HTRANS}); end
        end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%0b exp=1", cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_error_replay();
        test_burst();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
